// File: rtl/soc.sv
// Single-cycle MIPS-32 system: core, program ROM, data RAM and GPIO.
// The program image is supplied as the IMEM_IMAGE parameter at elaboration.
`timescale 1ns/1ps

package soc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
    typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_sel_t;
    typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_LINK, WB_HI, WB_LO} wb_sel_t;

    // Decoded control for one instruction; all-zero fields mean "nop".
    typedef struct packed {
        logic     reg_write;
        dst_sel_t dst_sel;
        logic     alu_src_imm;
        alu_op_t  alu_op;
        logic     mem_write;
        logic     hilo_write;
        logic     branch_eq;
        logic     branch_ne;
        logic     jump;
        logic     jump_reg;
        wb_sel_t  wb_sel;
    } ctrl_t;

endpackage

// 32x32 register file: two operand read ports, one debug read port, one write port.
module mips_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  ra3,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3
);

    logic [31:0] rf [32];

    // Register writes at the edge; reset clears every architectural register.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    // NOTE: the register file is architectural state and is cleared on reset;
    //       the data RAM is not, so it stays a plain memory without reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            rf[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];
    assign rd3 = (ra3 == 5'd0) ? 32'd0 : rf[ra3];

endmodule

// Instruction decoder: opcode/funct to control bundle.
module mips_control
    import soc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    // Decode; unknown opcodes and functs fall through to the nop defaults.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch.
        ctrl.reg_write   = 1'b0;
        ctrl.dst_sel     = DST_RT;
        ctrl.alu_src_imm = 1'b0;
        ctrl.alu_op      = ALU_ADD;
        ctrl.mem_write   = 1'b0;
        ctrl.hilo_write  = 1'b0;
        ctrl.branch_eq   = 1'b0;
        ctrl.branch_ne   = 1'b0;
        ctrl.jump        = 1'b0;
        ctrl.jump_reg    = 1'b0;
        ctrl.wb_sel      = WB_ALU;
        case (opcode)
            OP_RTYPE: begin
                ctrl.dst_sel = DST_RD;
                case (funct)
                    FN_ADD:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
                    FN_SUB:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
                    FN_AND:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
                    FN_OR:    begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
                    FN_SLT:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
                    FN_JR:    ctrl.jump_reg   = 1'b1;
                    FN_MULTU: ctrl.hilo_write = 1'b1;
                    FN_MFHI:  begin ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_HI; end
                    FN_MFLO:  begin ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_LO; end
                    default:  ;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OP_SLTI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = ALU_SLT;
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.wb_sel      = WB_MEM;
            end
            OP_SW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
            end
            OP_BEQ: ctrl.branch_eq = 1'b1;
            OP_BNE: ctrl.branch_ne = 1'b1;
            OP_J:   ctrl.jump      = 1'b1;
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RA;
                ctrl.wb_sel    = WB_LINK;
            end
            default: ;
        endcase
    end

endmodule

// Datapath: PC, register file, ALU, HI/LO and write-back selection.
module mips_datapath
    import soc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  ctrl_t       ctrl,
    input  logic [31:0] read_data,
    input  logic [4:0]  rf_ra2,
    output logic [31:0] rf_rd2,
    output logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic [31:0] write_data
);

    logic [4:0]  rs, rt, rd, wb_addr;
    logic [31:0] rs_val, rt_val, imm_ext, src_b, wb_data;
    logic [31:0] pc_plus4, pc_next, branch_target, jump_target;
    logic [31:0] hi, lo;
    logic        branch_taken;

    assign rs = instruction[25:21];
    assign rt = instruction[20:16];
    assign rd = instruction[15:11];

    assign imm_ext       = {{16{instruction[15]}}, instruction[15:0]};
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
    assign branch_taken  = (ctrl.branch_eq && (rs_val == rt_val)) ||
                           (ctrl.branch_ne && (rs_val != rt_val));

    mips_regfile RF (
        .clock (clock),
        .reset (reset),
        .we    (ctrl.reg_write),
        .ra1   (rs),
        .ra2   (rt),
        .ra3   (rf_ra2),
        .wa    (wb_addr),
        .wd    (wb_data),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .rd3   (rf_rd2)
    );

    assign src_b      = ctrl.alu_src_imm ? imm_ext : rt_val;
    assign write_data = rt_val;

    // ALU: two's complement arithmetic, overflow ignored, signed set-less-than.
    always_comb begin
        alu_out = rs_val + src_b;
        case (ctrl.alu_op)
            ALU_SUB: alu_out = rs_val - src_b;
            ALU_AND: alu_out = rs_val & src_b;
            ALU_OR:  alu_out = rs_val | src_b;
            ALU_SLT: alu_out = {31'd0, ($signed(rs_val) < $signed(src_b))};
            default: ;
        endcase
    end

    // Next PC: jr has priority, then jumps, then taken branches, else fall-through.
    always_comb begin
        pc_next = pc_plus4;
        if (ctrl.jump_reg)  pc_next = rs_val;
        else if (ctrl.jump) pc_next = jump_target;
        else if (branch_taken) pc_next = branch_target;
    end

    // Program counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc <= '0;
        else        pc <= pc_next;
    end

    // HI:LO captures the full 64-bit unsigned product on multu.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (ctrl.hilo_write) begin
            {hi, lo} <= {32'd0, rs_val} * {32'd0, rt_val};
        end
    end

    // Destination register: rt for I-type, rd for R-type, $31 for jal.
    always_comb begin
        wb_addr = rt;
        case (ctrl.dst_sel)
            DST_RD:  wb_addr = rd;
            DST_RA:  wb_addr = 5'd31;
            default: ;
        endcase
    end

    // Write-back value; jal links to pc+8.
    always_comb begin
        wb_data = alu_out;
        case (ctrl.wb_sel)
            WB_MEM:  wb_data = read_data;
            WB_LINK: wb_data = pc + 32'd8;
            WB_HI:   wb_data = hi;
            WB_LO:   wb_data = lo;
            default: ;
        endcase
    end

endmodule

// Core: decoder plus datapath.
module mips
    import soc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] read_data,
    input  logic [4:0]  rf_ra2,
    output logic [31:0] rf_rd2,
    output logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic        mem_we,
    output logic [31:0] write_data
);

    ctrl_t ctrl;

    mips_control CU (
        .opcode (instruction[31:26]),
        .funct  (instruction[5:0]),
        .ctrl   (ctrl)
    );

    mips_datapath DP (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .ctrl        (ctrl),
        .read_data   (read_data),
        .rf_ra2      (rf_ra2),
        .rf_rd2      (rf_rd2),
        .pc          (pc),
        .alu_out     (alu_out),
        .write_data  (write_data)
    );

    // Stores are suppressed while reset is held so an aborted sw writes nothing.
    assign mem_we = ctrl.mem_write & reset;

endmodule

// Top level: core, 64-word program ROM, 256-word data RAM, GPIO ports.
module soc #(
    parameter logic [63:0][31:0] IMEM_IMAGE = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  gpio_in,
    input  logic [4:0]  rf_ra2,
    output logic [31:0] rf_rd2,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic        dmem_we,
    output logic [31:0] dmem_wd,
    output logic [15:0] gpio_out
);

    logic [31:0] dmem [256];
    logic [31:0] read_data;
    logic        sel_ram, sel_gpio_out, sel_gpio_in;

    assign instruction = IMEM_IMAGE[pc[7:2]];

    mips MIPS (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .read_data   (read_data),
        .rf_ra2      (rf_ra2),
        .rf_rd2      (rf_rd2),
        .pc          (pc),
        .alu_out     (alu_out),
        .mem_we      (dmem_we),
        .write_data  (dmem_wd)
    );

    // Word-granular address decode; byte offset bits are ignored.
    assign sel_ram      = (alu_out[31:10] == 22'd0);
    assign sel_gpio_out = (alu_out[31:2] == 30'h200);
    assign sel_gpio_in  = (alu_out[31:2] == 30'h201);

    // Data RAM write port.
    always_ff @(posedge clock) begin
        if (dmem_we && sel_ram) dmem[alu_out[9:2]] <= dmem_wd;
    end

    // GPIO output register, written by a store to 0x800.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                         gpio_out <= '0;
        else if (dmem_we && sel_gpio_out)   gpio_out <= dmem_wd[15:0];
    end

    // Load data mux; unmapped addresses read as zero.
    always_comb begin
        read_data = 32'd0;
        if (sel_ram)           read_data = dmem[alu_out[9:2]];
        else if (sel_gpio_in)  read_data = {26'd0, gpio_in};
        else if (sel_gpio_out) read_data = {16'd0, gpio_out};
    end

endmodule

// File: tb/tb_soc.sv
// Bench for soc: recursive 4! program, GPIO, multu/HI/LO, ALU ops, branches,
// and reset both at start and in the middle of a run.
`timescale 1ns/1ps

module tb_soc;

    // Program image (addresses in comments).
    function automatic logic [63:0][31:0] build_prog();
        logic [63:0][31:0] p;
        p = '0;
        p[6'h00] = 32'h201D0200; // 00 addi $29,$0,0x200
        p[6'h01] = 32'h0C000005; // 04 jal  0x14
        p[6'h03] = 32'h00403820; // 0C add  $7,$2,$0
        p[6'h04] = 32'h0800001E; // 10 j    0x78
        p[6'h05] = 32'h20040004; // 14 addi $4,$0,4
        p[6'h06] = 32'hAFA4FFFC; // 18 fact: sw $4,-4($29)
        p[6'h07] = 32'hAFBFFFF8; // 1C sw   $31,-8($29)
        p[6'h08] = 32'h23BDFFF8; // 20 addi $29,$29,-8
        p[6'h09] = 32'h28880002; // 24 slti $8,$4,2
        p[6'h0A] = 32'h11000003; // 28 beq  $8,$0,0x38
        p[6'h0B] = 32'h20020001; // 2C addi $2,$0,1
        p[6'h0C] = 32'h23BD0008; // 30 addi $29,$29,8
        p[6'h0D] = 32'h03E00008; // 34 jr   $31
        p[6'h0E] = 32'h2084FFFF; // 38 addi $4,$4,-1
        p[6'h12] = 32'h0C000006; // 48 jal  0x18
        p[6'h14] = 32'h8FBF0000; // 50 lw   $31,0($29)
        p[6'h15] = 32'h8FA40004; // 54 lw   $4,4($29)
        p[6'h16] = 32'h23BD0008; // 58 addi $29,$29,8
        p[6'h17] = 32'h00440019; // 5C multu $2,$4
        p[6'h18] = 32'h00001012; // 60 mflo $2
        p[6'h19] = 32'h03E00008; // 64 jr   $31
        p[6'h1D] = 32'h0800001D; // 74 j    0x74
        p[6'h1E] = 32'h8C0D0804; // 78 lw   $13,0x804($0)
        p[6'h1F] = 32'h2011002A; // 7C addi $17,$0,0x2A
        p[6'h20] = 32'h15B10013; // 80 bne  $13,$17,0xD0
        p[6'h21] = 32'h1631FFFF; // 84 bne  $17,$17,-1
        p[6'h22] = 32'h2009ABCD; // 88 addi $9,$0,0xABCD
        p[6'h23] = 32'h200A4000; // 8C addi $10,$0,0x4000
        p[6'h24] = 32'h014A5020; // 90 add  $10,$10,$10
        p[6'h25] = 32'h014A5020; // 94 add  $10,$10,$10
        p[6'h26] = 32'h012A0019; // 98 multu $9,$10
        p[6'h27] = 32'h00004812; // 9C mflo $9
        p[6'h28] = 32'h21291234; // A0 addi $9,$9,0x1234
        p[6'h29] = 32'hAC090800; // A4 sw   $9,0x800($0)
        p[6'h2A] = 32'h2002FFFF; // A8 addi $2,$0,-1
        p[6'h2B] = 32'h00420019; // AC multu $2,$2
        p[6'h2C] = 32'h00005810; // B0 mfhi $11
        p[6'h2D] = 32'h00006012; // B4 mflo $12
        p[6'h2E] = 32'h00119022; // B8 sub  $18,$0,$17
        p[6'h2F] = 32'h0251982A; // BC slt  $19,$18,$17
        p[6'h30] = 32'h012AA024; // C0 and  $20,$9,$10
        p[6'h31] = 32'h0131A825; // C4 or   $21,$9,$17
        p[6'h32] = 32'h2A36FFFF; // C8 slti $22,$17,-1
        p[6'h33] = 32'h0800001D; // CC j    0x74
        p[6'h34] = 32'h1000FFFF; // D0 beq  $0,$0,-1
        return p;
    endfunction

    localparam logic [63:0][31:0] PROG = build_prog();

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  gpio_in;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd2, instruction, pc, alu_out, dmem_wd;
    logic        dmem_we;
    logic [15:0] gpio_out;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    store_t exp_q[$];

    always #5 clock = ~clock;

    soc #(.IMEM_IMAGE(PROG)) dut (
        .clock       (clock),
        .reset       (reset),
        .gpio_in     (gpio_in),
        .rf_ra2      (rf_ra2),
        .rf_rd2      (rf_rd2),
        .instruction (instruction),
        .pc          (pc),
        .alu_out     (alu_out),
        .dmem_we     (dmem_we),
        .dmem_wd     (dmem_wd),
        .gpio_out    (gpio_out)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_reg(input string name, input logic [4:0] idx, input logic [31:0] expected);
        rf_ra2 = idx;
        #1;
        check(name, rf_rd2, expected);
    endtask

    task automatic wait_pc(input string name, input logic [31:0] target, input int budget);
        int n;
        n = 0;
        while (pc !== target && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (pc !== target) begin
            failures++;
            $display("FAIL %s: pc=0x%08h never reached 0x%08h", name, pc, target);
        end
    endtask

    task automatic push_store(input logic [31:0] addr, input logic [31:0] data);
        store_t s;
        s.addr = addr;
        s.data = data;
        exp_q.push_back(s);
    endtask

    // Stack traffic of fact(4): argument then return address per frame.
    task automatic push_fact_stores();
        push_store(32'h1FC, 32'h4);  push_store(32'h1F8, 32'hC);
        push_store(32'h1F4, 32'h3);  push_store(32'h1F0, 32'h50);
        push_store(32'h1EC, 32'h2);  push_store(32'h1E8, 32'h50);
        push_store(32'h1E4, 32'h1);  push_store(32'h1E0, 32'h50);
    endtask

    // Store monitor: every sw cycle is matched against the next expected store.
    always @(negedge clock) begin
        store_t e;
        if (reset === 1'b1 && dmem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_store: addr=0x%08h data=0x%08h, none expected", alu_out, dmem_wd);
            end else begin
                e = exp_q.pop_front();
                check("store_addr", alu_out, e.addr);
                check("store_data", dmem_wd, e.data);
            end
        end
    end

    initial begin
        reset   = 1'b0;
        gpio_in = 6'h2A;
        rf_ra2  = 5'd0;
        repeat (2) @(negedge clock);

        // Reset state.
        check("reset_pc", pc, 32'h0);
        check("reset_gpio_out", {16'h0, gpio_out}, 32'h0);
        check("reset_instruction", instruction, 32'h201D0200);
        check("reset_dmem_we", {31'h0, dmem_we}, 32'h0);
        for (int r = 0; r < 32; r++) check_reg("reset_rf", r[4:0], 32'h0);

        push_fact_stores();
        push_store(32'h800, 32'hABCD1234);

        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("pc_after_release", pc, 32'h4);
        check("jal_instruction", instruction, 32'h0C000005);
        @(negedge clock);
        check("jal_target", pc, 32'h14);
        check_reg("jal_link", 5'd31, 32'hC);

        wait_pc("jr_return_to_0xC", 32'hC, 400);
        wait_pc("reach_self_jump", 32'h74, 200);
        check("self_jump_instruction", instruction, 32'h0800001D);
        check_reg("fact_result_r7", 5'd7, 32'h18);
        check_reg("sp_restored", 5'd29, 32'h200);
        check_reg("lw_gpio_in", 5'd13, 32'h2A);
        check_reg("built_constant", 5'd9, 32'hABCD1234);
        check_reg("addi_minus1", 5'd2, 32'hFFFFFFFF);
        check_reg("mfhi", 5'd11, 32'hFFFFFFFE);
        check_reg("mflo", 5'd12, 32'h00000001);
        check_reg("sub", 5'd18, 32'hFFFFFFD6);
        check_reg("slt_signed", 5'd19, 32'h1);
        check_reg("and", 5'd20, 32'h00010000);
        check_reg("or", 5'd21, 32'hABCD123E);
        check_reg("slti_signed", 5'd22, 32'h0);
        check_reg("r0_reads_zero", 5'd0, 32'h0);
        check("gpio_out_written", {16'h0, gpio_out}, 32'h1234);
        check("stores_drained_run1", exp_q.size(), 32'h0);
        @(negedge clock);
        check("self_jump_holds", pc, 32'h74);

        // Asynchronous reset mid-program, between clock edges.
        #1 reset = 1'b0;
        #1;
        check("async_reset_pc", pc, 32'h0);
        check("async_reset_gpio_out", {16'h0, gpio_out}, 32'h0);
        check_reg("async_reset_r7", 5'd7, 32'h0);

        gpio_in = 6'h15;
        push_fact_stores();
        @(negedge clock);
        check("held_reset_dmem_we", {31'h0, dmem_we}, 32'h0);
        reset = 1'b1;

        wait_pc("reach_beq_loop", 32'hD0, 400);
        check("beq_instruction", instruction, 32'h1000FFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("beq_loops_in_place", pc, 32'hD0);
        end
        check_reg("lw_gpio_in_run2", 5'd13, 32'h15);
        check_reg("fact_result_run2", 5'd7, 32'h18);
        check("gpio_out_untouched_run2", {16'h0, gpio_out}, 32'h0);
        check("stores_drained_run2", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
